// File: rtl/multi_slow_clock.sv
// NUM_CH independent programmable clock dividers on clk_in, each producing a
// terminal-count tick strobe, a 50%-duty toggled slow clock and a running flag.
module multi_slow_clock #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 12_500_000,
  parameter int unsigned AUTO_RUN    = 1,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic             RUN_RST = (AUTO_RUN != 0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] count_q;
    logic             mode_q;
    logic             run_q;
    logic             tick_q;
    logic             clk_q;
    logic             cfg_hit_c;

    // Out-of-range channel numbers never match any instance, so such writes drop.
    assign cfg_hit_c = cfg_we && (cfg_ch == CH_W'(i));

    // Priority: reset > config write > stop > start > counting.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        div_q   <= DIV_RST;
        count_q <= '0;
        mode_q  <= 1'b0;
        run_q   <= RUN_RST;
        tick_q  <= 1'b0;
        clk_q   <= 1'b0;
      end else if (cfg_hit_c) begin
        div_q   <= cfg_div;
        mode_q  <= cfg_mode;
        count_q <= '0;
        run_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else if (stop[i]) begin
        run_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (start[i]) begin
        run_q   <= 1'b1;
        count_q <= '0;
        tick_q  <= 1'b0;
      end else if (run_q) begin
        if (count_q == div_q) begin
          count_q <= '0;
          tick_q  <= 1'b1;
          clk_q   <= ~clk_q;
          if (mode_q) begin
            run_q <= 1'b0;
          end
        end else begin
          count_q <= count_q + CNT_W'(1);
          tick_q  <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign tick[i]    = tick_q;
    assign clk_out[i] = clk_q;
    assign busy[i]    = run_q;
  end

endmodule

// File: tb/tb_multi_slow_clock.sv
// Directed bench for multi_slow_clock: 3 channels, 8-bit counters, divisor 3,
// auto-run after reset. Inputs change and outputs are sampled 1 ns after posedge.
module tb_multi_slow_clock;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CH_W   = 2;

  logic              clk_in;
  logic              rst;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  multi_slow_clock #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(3),
    .AUTO_RUN(1)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
    .start(start),
    .stop(stop),
    .tick(tick),
    .clk_out(clk_out),
    .busy(busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    start = '0; stop = '0;
    step(); step();
    n_checks++;
    if (tick !== 3'b000) begin n_fail++; $display("FAIL reset_tick: got %b expected 000", tick); end
    n_checks++;
    if (clk_out !== 3'b000) begin n_fail++; $display("FAIL reset_clk_out: got %b expected 000", clk_out); end
    n_checks++;
    if (busy !== 3'b111) begin n_fail++; $display("FAIL reset_busy: got %b expected 111", busy); end
    rst = 1'b0;
    // Auto-run with divisor 3: tick every 4th edge, clk_out 1,0,1.
    for (int c = 1; c <= 12; c++) begin
      logic [2:0] exp_tick;
      logic [2:0] exp_clk;
      step();
      exp_tick = (c % 4 == 0) ? 3'b111 : 3'b000;
      n_checks++;
      if (tick !== exp_tick) begin
        n_fail++; $display("FAIL autorun_tick c=%0d: got %b expected %b", c, tick, exp_tick);
      end
      if (c % 4 == 0) begin
        exp_clk = ((c / 4) % 2 == 1) ? 3'b111 : 3'b000;
        n_checks++;
        if (clk_out !== exp_clk) begin
          n_fail++; $display("FAIL autorun_clk c=%0d: got %b expected %b", c, clk_out, exp_clk);
        end
      end
    end
  endtask

  task automatic test_reprogram();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0; cfg_mode = 1'b0;
    step();
    cfg_we = 1'b0;
    n_checks++;
    if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL reprog_idle_busy: got %b expected 0", busy[1]); end
    start = 3'b010;
    step();
    start = '0;
    n_checks++;
    if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL reprog_busy: got %b expected 1", busy[1]); end
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (tick[1] !== 1'b1) begin n_fail++; $display("FAIL div0_tick k=%0d: got %b expected 1", k, tick[1]); end
      n_checks++;
      if (clk_out[1] !== (k % 2 == 0)) begin
        n_fail++; $display("FAIL div0_clk k=%0d: got %b expected %b", k, clk_out[1], (k % 2 == 0));
      end
      n_checks++;
      if (tick[0] !== (k == 2 || k == 6)) begin
        n_fail++; $display("FAIL ch0_unaffected_tick k=%0d: got %b expected %b", k, tick[0], (k == 2 || k == 6));
      end
    end
    n_checks++;
    if (clk_out[0] !== 1'b1) begin n_fail++; $display("FAIL ch0_unaffected_clk: got %b expected 1", clk_out[0]); end
  endtask

  task automatic test_one_shot();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5; cfg_mode = 1'b1;
    step();
    cfg_we = 1'b0;
    start = 3'b001;
    step();
    start = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (tick[0] !== (k == 6)) begin n_fail++; $display("FAIL oneshot_tick k=%0d: got %b expected %b", k, tick[0], (k == 6)); end
      n_checks++;
      if (busy[0] !== (k < 6)) begin n_fail++; $display("FAIL oneshot_busy k=%0d: got %b expected %b", k, busy[0], (k < 6)); end
    end
    n_checks++;
    if (clk_out[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_clk: got %b expected 0", clk_out[0]); end
    for (int k = 1; k <= 50; k++) begin
      step();
      n_checks++;
      if ({tick[0], busy[0], clk_out[0]} !== 3'b000) begin
        n_fail++; $display("FAIL oneshot_quiet k=%0d: got tick/busy/clk %b expected 000", k, {tick[0], busy[0], clk_out[0]});
      end
    end
  endtask

  task automatic test_stop_restart();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; cfg_mode = 1'b0;
    step();
    cfg_we = 1'b0;
    start = 3'b001;
    step();
    start = '0;
    step(); step();
    stop = 3'b001;
    step();
    stop = '0;
    n_checks++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b expected 0", busy[0]); end
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if ({tick[0], clk_out[0]} !== 2'b00) begin
        n_fail++; $display("FAIL stopped_hold k=%0d: got tick/clk %b expected 00", k, {tick[0], clk_out[0]});
      end
    end
    start = 3'b001;
    step();
    start = '0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (tick[0] !== (k == 4)) begin n_fail++; $display("FAIL restart_tick k=%0d: got %b expected %b", k, tick[0], (k == 4)); end
    end
    n_checks++;
    if (clk_out[0] !== 1'b1) begin n_fail++; $display("FAIL restart_clk: got %b expected 1", clk_out[0]); end
    stop = 3'b001;
    step();
    stop = '0;
  endtask

  task automatic test_collisions();
    start = 3'b010; stop = 3'b010;
    step();
    start = '0; stop = '0;
    n_checks++;
    if ({busy[1], tick[1]} !== 2'b00) begin
      n_fail++; $display("FAIL start_stop_collide: got busy/tick %b expected 00", {busy[1], tick[1]});
    end
    start = 3'b010;
    step();
    n_checks++;
    if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL collide_restart_busy: got %b expected 1", busy[1]); end
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2; cfg_mode = 1'b0;
    step();
    cfg_we = 1'b0; start = '0;
    n_checks++;
    if ({busy[1], tick[1]} !== 2'b00) begin
      n_fail++; $display("FAIL cfg_start_collide: got busy/tick %b expected 00", {busy[1], tick[1]});
    end
    // Start all channels, then an out-of-range write must leave every divisor alone.
    start = 3'b111;
    step();
    start = '0;
    n_checks++;
    if (busy !== 3'b111) begin n_fail++; $display("FAIL all_start_busy: got %b expected 111", busy); end
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0; cfg_mode = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] exp_tick;
      step();
      cfg_we = 1'b0;
      exp_tick = {(k % 4 == 0), (k % 3 == 0), (k % 4 == 0)};
      n_checks++;
      if (tick !== exp_tick) begin n_fail++; $display("FAIL bad_ch_tick k=%0d: got %b expected %b", k, tick, exp_tick); end
      n_checks++;
      if (busy !== 3'b111) begin n_fail++; $display("FAIL bad_ch_busy k=%0d: got %b expected 111", k, busy); end
    end
    n_checks++;
    if (clk_out[0] !== 1'b1) begin n_fail++; $display("FAIL bad_ch_clk0: got %b expected 1", clk_out[0]); end
  endtask

  task automatic test_mid_reset();
    start = 3'b001;
    step();
    start = '0;
    step(); step();
    n_checks++;
    if ({tick[0], clk_out[0]} !== 2'b01) begin
      n_fail++; $display("FAIL pre_reset_ch0: got tick/clk %b expected 01", {tick[0], clk_out[0]});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({tick, clk_out} !== 6'b000000) begin
      n_fail++; $display("FAIL mid_reset_outs: got tick/clk %b expected 000000", {tick, clk_out});
    end
    n_checks++;
    if (busy !== 3'b111) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 111", busy); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (tick !== ((k == 4) ? 3'b111 : 3'b000)) begin
        n_fail++; $display("FAIL post_reset_tick k=%0d: got %b expected %b", k, tick, (k == 4) ? 3'b111 : 3'b000);
      end
    end
    n_checks++;
    if (clk_out !== 3'b111) begin n_fail++; $display("FAIL post_reset_clk: got %b expected 111", clk_out); end
  endtask

  initial begin
    test_reset();
    test_reprogram();
    test_one_shot();
    test_stop_restart();
    test_collisions();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
